// File: rtl/signed_div_seq.sv
// rtl/signed_div_seq.sv - sequential sign-magnitude restoring divider with start/busy/done handshake
// Magnitudes are divided unsigned over WIDTH steps; signs are applied in a single fix-up cycle.
module signed_div_seq #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       sel,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             s0,
   input  logic             s1,
   output logic             busy,
   output logic             done,
   output logic [WIDTH:0]   Q,
   output logic [WIDTH:0]   R,
   output logic             dbz
);

   localparam int         CW      = $clog2(WIDTH + 1);
   localparam logic [1:0] SEL_DIV = 2'b10;

   typedef enum logic [1:0] {
      IDLE,
      DIV,
      FIX
   } state_t;

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] p;
   logic [WIDTH-1:0] d;
   logic [WIDTH-1:0] bm;
   logic             sa;
   logic             sb;
   logic             zflag;

   logic [WIDTH:0]   t;
   logic             ge;
   logic [WIDTH-1:0] diff;
   logic [WIDTH:0]   qmag;
   logic [WIDTH:0]   rmag;

   // When t >= bm the true difference is below bm, so WIDTH bits hold it exactly.
   always_comb begin
      t    = {p, d[WIDTH-1]};
      ge   = (t >= {1'b0, bm});
      diff = t[WIDTH-1:0] - bm;
      qmag = {1'b0, d};
      rmag = {1'b0, p};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         cnt   <= '0;
         p     <= '0;
         d     <= '0;
         bm    <= '0;
         sa    <= 1'b0;
         sb    <= 1'b0;
         zflag <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
         Q     <= '0;
         R     <= '0;
         dbz   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start && sel == SEL_DIV) begin
                  d     <= A;
                  bm    <= B;
                  sa    <= s0;
                  sb    <= s1;
                  p     <= '0;
                  cnt   <= CW'(WIDTH);
                  zflag <= (B == '0);
                  busy  <= 1'b1;
                  state <= (B == '0) ? FIX : DIV;
               end
            end
            DIV: begin
               p   <= ge ? diff : t[WIDTH-1:0];
               d   <= {d[WIDTH-2:0], ge};
               cnt <= cnt - CW'(1);
               if (cnt == CW'(1)) begin
                  state <= FIX;
               end
            end
            FIX: begin
               // Truncating division: the remainder follows the dividend's sign.
               if (zflag) begin
                  Q   <= '0;
                  R   <= '0;
                  dbz <= 1'b1;
               end else begin
                  Q   <= (sa ^ sb) ? -qmag : qmag;
                  R   <= sa ? -rmag : rmag;
                  dbz <= 1'b0;
               end
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_signed_div_seq.sv
// tb/tb_signed_div_seq.sv - scoreboard bench for signed_div_seq
module tb_signed_div_seq;

   localparam int W = 4;

   logic         clk   = 1'b0;
   logic         reset = 1'b1;
   logic         start = 1'b0;
   logic [1:0]   sel   = 2'b00;
   logic [W-1:0] A     = '0;
   logic [W-1:0] B     = '0;
   logic         s0    = 1'b0;
   logic         s1    = 1'b0;
   logic         busy;
   logic         done;
   logic         dbz;
   logic [W:0]   Q;
   logic [W:0]   R;

   typedef struct packed {
      logic [W:0] q;
      logic [W:0] r;
      logic       z;
   } exp_t;

   exp_t sb_q[$];
   int   n_chk  = 0;
   int   n_pass = 0;
   logic done_d = 1'b0;

   always #5 clk = ~clk;

   signed_div_seq #(.WIDTH(W)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .sel   (sel),
      .A     (A),
      .B     (B),
      .s0    (s0),
      .s1    (s1),
      .busy  (busy),
      .done  (done),
      .Q     (Q),
      .R     (R),
      .dbz   (dbz)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
   endtask

   function automatic exp_t model(input int a, input int b, input bit sa, input bit sb);
      exp_t e;
      int   qm;
      int   rm;
      if (b == 0) begin
         e.q = '0;
         e.r = '0;
         e.z = 1'b1;
      end else begin
         qm = a / b;
         rm = a % b;
         if (sa ^ sb) qm = -qm;
         if (sa) rm = -rm;
         e.q = qm[W:0];
         e.r = rm[W:0];
         e.z = 1'b0;
      end
      return e;
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (done) begin
         check("done_expected", (sb_q.size() != 0), 1);
         check("done_one_cycle", done_d, 0);
         if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check("Q", Q, e.q);
            check("R", R, e.r);
            check("dbz", dbz, e.z);
         end
      end
      done_d = done;
   end

   task automatic issue(input int a, input int b, input bit sa, input bit sb, input bit push);
      @(negedge clk);
      A     = a[W-1:0];
      B     = b[W-1:0];
      s0    = sa;
      s1    = sb;
      sel   = 2'b10;
      start = 1'b1;
      if (push) sb_q.push_back(model(a, b, sa, sb));
   endtask

   task automatic accept_and_scramble();
      @(posedge clk);
      #1;
      start = 1'b0;
      A     = W'($urandom);
      B     = W'($urandom);
      s0    = 1'($urandom);
      s1    = 1'($urandom);
      sel   = 2'($urandom);
   endtask

   task automatic wait_done(input int exp_lat, input bit poke);
      int j;
      j = 0;
      while (j < 40) begin
         @(negedge clk);
         if (done) break;
         check("busy_during", busy, 1);
         if (poke) begin
            start = 1'b1;
            sel   = j[0] ? 2'b10 : 2'b01;
         end
         j++;
      end
      if (poke) start = 1'b0;
      check("latency", j, exp_lat);
      check("busy_at_done", busy, 0);
   endtask

   task automatic run(input int a, input int b, input bit sa, input bit sb);
      issue(a, b, sa, sb, 1'b1);
      accept_and_scramble();
      wait_done((b == 0) ? 1 : W + 1, 1'b0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      #2 reset = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_Q", Q, 0);
      check("rst_R", R, 0);
      check("rst_dbz", dbz, 0);
      reset = 1'b1;

      run(7, 2, 1'b0, 1'b0);
      run(7, 2, 1'b1, 1'b0);
      run(15, 1, 1'b0, 1'b1);
      run(15, 1, 1'b1, 1'b1);
      run(9, 0, 1'b0, 1'b0);
      run(6, 3, 1'b0, 1'b0);

      // starts while busy and with a non-divide select must not launch anything
      issue(13, 3, 1'b1, 1'b0, 1'b1);
      accept_and_scramble();
      wait_done(W + 1, 1'b1);
      @(negedge clk);
      start = 1'b1;
      sel   = 2'b01;
      repeat (3) begin
         @(negedge clk);
         check("sel_ignored", busy, 0);
      end
      start = 1'b0;

      // start held through done: the second request is taken in the done cycle
      issue(15, 1, 1'b1, 1'b1, 1'b1);
      @(posedge clk);
      wait_done(W + 1, 1'b0);
      A  = 4'd6;
      B  = 4'd3;
      s0 = 1'b1;
      s1 = 1'b0;
      sb_q.push_back(model(6, 3, 1'b1, 1'b0));
      @(posedge clk);
      #1 start = 1'b0;
      wait_done(W + 1, 1'b0);

      for (int i = 0; i < 10; i++) begin
         int a;
         int b;
         a = $urandom_range(0, 15);
         b = (i % 4 == 3) ? 0 : $urandom_range(1, 15);
         run(a, b, 1'($urandom), 1'($urandom));
      end

      run(14, 4, 1'b1, 1'b1);
      issue(13, 3, 1'b0, 1'b1, 1'b0);
      accept_and_scramble();
      repeat (2) @(negedge clk);
      reset = 1'b0;
      #1;
      check("midrst_busy", busy, 0);
      check("midrst_done", done, 0);
      check("midrst_Q", Q, 0);
      check("midrst_R", R, 0);
      check("midrst_dbz", dbz, 0);
      @(negedge clk);
      reset = 1'b1;
      repeat (10) @(negedge clk);
      check("post_rst_busy", busy, 0);
      check("post_rst_Q", Q, 0);

      check("sb_empty", sb_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
